fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that feeds the control FSM.
- Owns the program counter and the instruction register (IR), and runs a req/ack handshake to instruction memory.
- Presents opcode/operand to control and applies control's pc_load/pc_en/jmp commands to the PC.
- Bounds the memory wait with a timeout that forces a HALT instruction.

Parameters:
- DATA_W, 8, instruction width; IR = {opcode, operand}.
- OPC_W, 3, opcode field width (IR[DATA_W-1 -: OPC_W]).
- TIMEOUT_CYC, 15, max cycles imem_req may wait for imem_ack before abort; must be ≥1.
- Derived localparam ADDR_W = DATA_W-OPC_W (5): PC/operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- memIns_en  in  1  fetch request from control; sampled only in IDLE.
- pc_en  in  1  increment PC.
- pc_load  in  1  load/skip PC.
- jmp  in  1  qualifies pc_load: 1 = jump to operand, 0 = skip (+1).
- halt  in  1  freeze PC, block new fetches.
- imem_req  out  1  memory request, held until ack or abort.
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1.
- imem_rdata  in  DATA_W  instruction data, valid when imem_ack=1.
- imem_ack  in  1  single-cycle data-valid strobe.
- opcode  out  OPC_W  IR opcode field, to control.
- operand  out  ADDR_W  IR operand field, to datapath/PC.
- ir_valid  out  1  IR holds a fetched instruction.
- pc  out  ADDR_W  current PC.
- fetch_busy  out  1  a fetch is outstanding.
- fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: pc=0, IR=0, ir_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, wait counter=0, state=IDLE.
- State machine: IDLE, REQ.
  - IDLE:
    - memIns_en=1 and halt=0 → next cycle imem_req=1, imem_addr=pc (registered copy), fetch_busy=1, state=REQ.
    - memIns_en with halt=1 → ignored.
  - REQ:
    - imem_req stays 1 and imem_addr stays stable.
    - Each cycle without ack increments the wait counter.
  - REQ with imem_ack=1:
    - Next cycle: IR<=imem_rdata, ir_valid=1, imem_req=0, fetch_busy=0, counter=0, state=IDLE.
    - Minimum latency is request cycle + ack cycle; data is visible on opcode/operand the cycle after ack.
  - REQ, counter reaches TIMEOUT_CYC with no ack:
    - Next cycle: imem_req=0, IR<=0 (HALT opcode), ir_valid=1, fetch_err=1 for exactly one cycle, state=IDLE.
  - memIns_en while in REQ is ignored; nothing is queued.
- Ack handling:
  - imem_ack while in IDLE is ignored; IR is unchanged.
  - Ack on the same cycle the timeout is reached: ack wins, no error.
- ir_valid:
  - Cleared the cycle after a new fetch is launched.
  - Held otherwise, so opcode is stable through decode/execute/writeback.
- PC update, evaluated every cycle when halt=0:
  - pc_load & jmp → pc<=operand.
  - pc_load & !jmp → pc<=pc+1.
  - else pc_en → pc<=pc+1.
  - Priority is pc_load over pc_en. Simultaneous pc_load & pc_en: only the load takes effect.
  - Increment wraps modulo 2^ADDR_W (31→0).
  - halt=1: pc frozen. An outstanding fetch still completes normally.
- PC and outstanding fetches: PC changes during REQ do not affect imem_addr, because the address is latched at launch.
- Reset mid-fetch: imem_req drops the cycle after rst. A late ack after reset is ignored.
- opcode/operand are combinational slices of the registered IR; no other combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg:
  - Opcode enum, 3-bit: HLT=0, STO=6, JMP=7, plus the remaining control-defined codes.
  - DATA_W/OPC_W defaults.
  - Fetch state enum {IDLE, REQ}.
- Sub-module pc_counter:
  - Ports: clk, rst, halt, pc_load, jmp, pc_en, operand, pc.
  - Implements the priority/wrap rules above.
- fetch_unit instantiates pc_counter and holds the FSM, IR, wait counter and error pulse.

Test Plan:
- Reset, then memIns_en pulse, memory acks 0 cycles after req with rdata=8'hE3 → imem_addr=0, opcode=7, operand=3, ir_valid=1; then pc_load=1, jmp=1 → pc=3.
- Memory acks after 4 wait cycles; pc_en pulsed and memIns_en re-asserted during the wait → imem_addr stays 0 until ack, IR loads only once, pc=1.
- No ack with TIMEOUT_CYC=15 → imem_req deasserts after 15 wait cycles; fetch_err high for exactly 1 cycle; opcode=0, ir_valid=1.
- pc=31, pc_en → pc=0. Simultaneous pc_load=1, jmp=0, pc_en=1 at pc=5 → pc=6.
- halt=1 with pc_en and memIns_en asserted for 10 cycles → pc unchanged, imem_req never asserted; an in-flight fetch launched before halt still completes.
- rst asserted in REQ, ack arrives 2 cycles later → all outputs at reset values, ack ignored, ir_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small teaching CPU: default widths, the opcode
// map used by the control FSM, and the state encoding of the fetch stage.
// No ports; imported by fetch_unit and pc_counter.
// ----------------------------------------------------------------------------
package cpu_pkg;

   // Default instruction geometry: an 8-bit word split into a 3-bit opcode
   // and a 5-bit operand, plus the longest memory wait before giving up.
   localparam int CPU_DATA_W      = 8;
   localparam int CPU_OPC_W       = 3;
   localparam int CPU_TIMEOUT_CYC = 15;

   // Opcode map. HLT must stay at zero: an aborted fetch clears the IR and
   // control then sees a halt.
   typedef enum logic [2:0] {
      HLT = 3'd0,
      LDA = 3'd1,
      ADD = 3'd2,
      SUB = 3'd3,
      AND = 3'd4,
      BNZ = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   // Fetch stage is either idle or waiting on an instruction-memory ack.
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetchState_t;

endpackage

// File: rtl/pc_counter.sv
// ----------------------------------------------------------------------------
// pc_counter
// Program counter for the fetch stage.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   halt          freezes the PC
//   pc_load, jmp  load command: jmp=1 jumps to operand, jmp=0 skips (+1)
//   pc_en         plain increment, lower priority than pc_load
//   operand       jump target taken from the instruction register
//   pc            current program counter
// ----------------------------------------------------------------------------
module pc_counter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_DATA_W - CPU_OPC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              pc_load,
   input  logic              jmp,
   input  logic              pc_en,
   input  logic [ADDR_W-1:0] operand,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Next-PC selection. A load always beats a plain increment, so a
   // simultaneous pc_load and pc_en moves the PC only once. Increments wrap
   // naturally at the top of the address space. Halt holds the PC.
   always_comb begin
      pc_d = pc_q;
      if (!halt) begin
         if (pc_load) begin
            if (jmp) begin
               pc_d = operand;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end else if (pc_en) begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // PC register with synchronous reset to address zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC (via pc_counter) and the instruction
// register, and runs a req/ack handshake to instruction memory with a bounded
// wait; a timed-out fetch loads a HALT instruction and pulses fetch_err.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   memIns_en                fetch request from control (honoured in IDLE)
//   pc_en, pc_load, jmp      PC commands from control
//   halt                     freeze PC and block new fetches
//   imem_req, imem_addr      memory request and its latched address
//   imem_rdata, imem_ack     returned instruction and its one-cycle strobe
//   opcode, operand          fields of the instruction register
//   ir_valid                 IR holds a fetched (or forced HALT) instruction
//   pc                       current program counter
//   fetch_busy               a fetch is outstanding
//   fetch_err                one-cycle pulse when a fetch times out
// ----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter  int DATA_W      = CPU_DATA_W,
   parameter  int OPC_W       = CPU_OPC_W,
   parameter  int TIMEOUT_CYC = CPU_TIMEOUT_CYC,
   localparam int ADDR_W      = DATA_W - OPC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memIns_en,
   input  logic              pc_en,
   input  logic              pc_load,
   input  logic              jmp,
   input  logic              halt,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ack,
   output logic [OPC_W-1:0]  opcode,
   output logic [ADDR_W-1:0] operand,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_busy,
   output logic              fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   fetchState_t       state_q;
   logic              imemReq_q;
   logic [ADDR_W-1:0] imemAddr_q;
   logic              fetchBusy_q;
   logic              fetchErr_q;
   logic              irValid_q;
   logic [DATA_W-1:0] ir_q;
   logic [CNT_W-1:0]  waitCnt_q;

   // The PC lives in its own block; it only ever jumps to the operand of the
   // instruction currently held in the IR.
   pc_counter #(
      .ADDR_W (ADDR_W)
   ) u_pc_counter (
      .clk     (clk),
      .rst     (rst),
      .halt    (halt),
      .pc_load (pc_load),
      .jmp     (jmp),
      .pc_en   (pc_en),
      .operand (ir_q[ADDR_W-1:0]),
      .pc      (pc)
   );

   // Fetch FSM with all outputs registered. A fetch launches from IDLE only
   // when control asks and we are not halted; the PC is copied into
   // imem_addr at launch so later PC moves cannot disturb the request.
   // In REQ the wait counter records cycles spent without an ack; the abort
   // is taken on the cycle the counter would reach TIMEOUT_CYC, so the
   // request is visible for exactly TIMEOUT_CYC cycles. An ack is checked
   // first, so it wins over a simultaneous timeout. Acks seen in IDLE and
   // fetch requests seen in REQ fall through untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         imemReq_q   <= 1'b0;
         imemAddr_q  <= '0;
         fetchBusy_q <= 1'b0;
         fetchErr_q  <= 1'b0;
         irValid_q   <= 1'b0;
         ir_q        <= '0;
         waitCnt_q   <= '0;
      end else begin
         fetchErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (memIns_en && !halt) begin
                  state_q     <= REQ;
                  imemReq_q   <= 1'b1;
                  imemAddr_q  <= pc;
                  fetchBusy_q <= 1'b1;
                  irValid_q   <= 1'b0;
                  waitCnt_q   <= '0;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  state_q     <= IDLE;
                  imemReq_q   <= 1'b0;
                  fetchBusy_q <= 1'b0;
                  ir_q        <= imem_rdata;
                  irValid_q   <= 1'b1;
                  waitCnt_q   <= '0;
               end else if (waitCnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state_q     <= IDLE;
                  imemReq_q   <= 1'b0;
                  fetchBusy_q <= 1'b0;
                  ir_q        <= '0;
                  irValid_q   <= 1'b1;
                  fetchErr_q  <= 1'b1;
                  waitCnt_q   <= '0;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Everything below is a straight copy or slice of registered state.
   assign imem_req   = imemReq_q;
   assign imem_addr  = imemAddr_q;
   assign fetch_busy = fetchBusy_q;
   assign fetch_err  = fetchErr_q;
   assign ir_valid   = irValid_q;
   assign opcode     = ir_q[DATA_W-1 -: OPC_W];
   assign operand    = ir_q[ADDR_W-1:0];

endmodule
